fl: RTL and testbench

- Free list for the 2-wide R10K-style rename stage.
- Sits directly upstream of the map table and supplies the new physical register tags fl_pr0/fl_pr1 used at dispatch.
- Physical registers are returned by ROB retirement (Told).
- On branch mispredict recovery, all speculatively allocated tags are reclaimed by rolling the head pointer back to a retire pointer.

---
 rtl/rename_pkg.sv | 20 ++
 rtl/fl.sv | 94 +++++++++
 tb/tb_fl.sv | 223 ++++++++++++++++++++++
 3 files changed

// File: rtl/rename_pkg.sv
//------------------------------------------------------------------------------
// Module  : rename_pkg
// Brief   : Rename-stage shared constants and tag type (free list, map, ROB).
// Rev     : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

package rename_pkg;

    localparam int PR_W     = 7;
    localparam int AR_W     = 5;
    localparam int PR_NUM   = 64;
    localparam int AR_NUM   = 32;
    localparam int FL_DEPTH = PR_NUM - AR_NUM;

    typedef logic [PR_W-1:0] pr_tag_t;

endpackage

`default_nettype wire

// File: rtl/fl.sv
//------------------------------------------------------------------------------
// Module  : fl
// Brief   : 2-wide circular free list of physical register tags with
//           retire-pointer rollback for mispredict recovery.
// Rev     : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module fl
    import rename_pkg::*;
#(
    parameter int FL_DEPTH = rename_pkg::FL_DEPTH,
    parameter int PR_W     = rename_pkg::PR_W,
    parameter int PTR_W    = 6
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [1:0]       id_dispatch_num,
    input  logic [1:0]       rob_retire_num,
    input  logic [PR_W-1:0]  rob_retire_told0,
    input  logic [PR_W-1:0]  rob_retire_told1,
    input  logic             rob_recover,
    output logic [PR_W-1:0]  fl_pr0,
    output logic [PR_W-1:0]  fl_pr1,
    output logic [1:0]       fl_avail,
    output logic [PTR_W-1:0] fl_free_cnt
);

    localparam int IDX_W = PTR_W - 1;

    logic [PR_W-1:0]  fl_buf_q [FL_DEPTH];
    logic [PTR_W-1:0] head_q, head_d;
    logic [PTR_W-1:0] rhead_q, rhead_d;
    logic [PTR_W-1:0] tail_q, tail_d;

    logic [PTR_W-1:0] w_free_cnt;
    logic [1:0]       w_avail;
    logic [1:0]       w_alloc;
    logic [IDX_W-1:0] w_head_idx1;
    logic [IDX_W-1:0] w_tail_idx0;
    logic [IDX_W-1:0] w_tail_idx1;

    // Availability uses pre-edge state only, so tags freed this cycle
    // cannot be handed out until the next one.
    always_comb begin
        w_free_cnt  = tail_q - head_q;
        w_avail     = (w_free_cnt >= PTR_W'(2)) ? 2'd2 : w_free_cnt[1:0];
        w_alloc     = (id_dispatch_num > w_avail) ? w_avail : id_dispatch_num;
        w_head_idx1 = head_q[IDX_W-1:0] + IDX_W'(1);
        w_tail_idx0 = tail_q[IDX_W-1:0];
        w_tail_idx1 = tail_q[IDX_W-1:0] + IDX_W'(1);

        rhead_d = rhead_q + PTR_W'(rob_retire_num);
        tail_d  = tail_q + PTR_W'(rob_retire_num);
        head_d  = rob_recover ? rhead_d : head_q + PTR_W'(w_alloc);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            head_q  <= '0;
            rhead_q <= '0;
            tail_q  <= PTR_W'(FL_DEPTH);
            for (int i = 0; i < FL_DEPTH; i++) begin
                fl_buf_q[i] <= PR_W'(FL_DEPTH + i);
            end
        end else begin
            head_q  <= head_d;
            rhead_q <= rhead_d;
            tail_q  <= tail_d;
            if (rob_retire_num != 2'd0) begin
                fl_buf_q[w_tail_idx0] <= rob_retire_told0;
            end
            if (rob_retire_num == 2'd2) begin
                fl_buf_q[w_tail_idx1] <= rob_retire_told1;
            end
        end
    end

    assign fl_pr0      = fl_buf_q[head_q[IDX_W-1:0]];
    assign fl_pr1      = fl_buf_q[w_head_idx1];
    assign fl_avail    = w_avail;
    assign fl_free_cnt = w_free_cnt;

`ifndef SYNTHESIS
    // Retiring more than is allocated would let tail overrun live tags.
    a_retire_legal: assert property (@(posedge clock) disable iff (reset)
        (rob_retire_num != 2'd3) && (PTR_W'(rob_retire_num) <= (head_q - rhead_q)));
    a_ring_full: assert property (@(posedge clock) disable iff (reset)
        (tail_q - rhead_q) == PTR_W'(FL_DEPTH));
`endif

endmodule

`default_nettype wire

// File: tb/tb_fl.sv
//------------------------------------------------------------------------------
// Module  : tb_fl
// Brief   : Directed and randomised self-checking bench for the free list.
// Rev     : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_fl;

    logic       clock = 1'b0;
    logic       reset;
    logic [1:0] id_dispatch_num;
    logic [1:0] rob_retire_num;
    logic [6:0] rob_retire_told0;
    logic [6:0] rob_retire_told1;
    logic       rob_recover;
    logic [6:0] fl_pr0;
    logic [6:0] fl_pr1;
    logic [1:0] fl_avail;
    logic [5:0] fl_free_cnt;

    int n_checks = 0;
    int n_errors = 0;

    logic [6:0] free_q[$];
    logic [6:0] infl_q[$];
    logic [6:0] comm_q[$];
    logic [5:0] ring_diff;

    fl dut (
        .clock            (clock),
        .reset            (reset),
        .id_dispatch_num  (id_dispatch_num),
        .rob_retire_num   (rob_retire_num),
        .rob_retire_told0 (rob_retire_told0),
        .rob_retire_told1 (rob_retire_told1),
        .rob_recover      (rob_recover),
        .fl_pr0           (fl_pr0),
        .fl_pr1           (fl_pr1),
        .fl_avail         (fl_avail),
        .fl_free_cnt      (fl_free_cnt)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clock);
        @(negedge clock);
    endtask

    task automatic drive(input logic [1:0] d, input logic [1:0] r,
                         input logic [6:0] t0, input logic [6:0] t1, input logic rec);
        id_dispatch_num  = d;
        rob_retire_num   = r;
        rob_retire_told0 = t0;
        rob_retire_told1 = t1;
        rob_recover      = rec;
    endtask

    task automatic idle();
        drive(2'd0, 2'd0, 7'd0, 7'd0, 1'b0);
    endtask

    task automatic do_reset();
        idle();
        reset = 1'b1;
        cyc();
        cyc();
        reset = 1'b0;
    endtask

    initial begin
        int d, r, maxr, ea, al;
        logic [6:0] t0, t1, tg;
        logic       rec;

        idle();
        reset = 1'b1;
        @(negedge clock);

        // 1: reset state
        do_reset();
        cyc();
        chk("rst_pr0", fl_pr0, 32);
        chk("rst_pr1", fl_pr1, 33);
        chk("rst_avail", fl_avail, 2);
        chk("rst_free", fl_free_cnt, 32);

        // 2: drain the whole list in pairs
        drive(2'd2, 2'd0, 7'd0, 7'd0, 1'b0);
        for (int k = 0; k < 16; k++) begin
            chk("drain_pr0", fl_pr0, 32 + 2 * k);
            chk("drain_pr1", fl_pr1, 33 + 2 * k);
            cyc();
        end
        chk("empty_free", fl_free_cnt, 0);
        chk("empty_avail", fl_avail, 0);
        cyc();
        chk("empty_head", dut.head_q, 32);
        chk("empty_free2", fl_free_cnt, 0);

        // 3: single free tag, same-cycle request allocates nothing
        drive(2'd2, 2'd1, 7'd5, 7'd0, 1'b0);
        cyc();
        idle();
        chk("one_avail", fl_avail, 1);
        chk("one_pr0", fl_pr0, 5);
        chk("one_free", fl_free_cnt, 1);
        drive(2'd2, 2'd0, 7'd0, 7'd0, 1'b0);
        cyc();
        idle();
        chk("one_clamp_free", fl_free_cnt, 0);
        chk("one_clamp_head", dut.head_q, 33);

        // 4: concurrent alloc and retire, then wrap to the freed tags
        do_reset();
        drive(2'd2, 2'd0, 7'd0, 7'd0, 1'b0);
        cyc();
        drive(2'd1, 2'd0, 7'd0, 7'd0, 1'b0);
        cyc();
        drive(2'd1, 2'd2, 7'd7, 7'd9, 1'b0);
        cyc();
        idle();
        chk("mix_head", dut.head_q, 4);
        chk("mix_tail", dut.tail_q, 34);
        chk("mix_free", fl_free_cnt, 30);
        chk("mix_pr0", fl_pr0, 36);
        drive(2'd2, 2'd0, 7'd0, 7'd0, 1'b0);
        for (int k = 0; k < 14; k++) cyc();
        idle();
        chk("wrap_free", fl_free_cnt, 2);
        chk("wrap_pr0", fl_pr0, 7);
        chk("wrap_pr1", fl_pr1, 9);

        // 5: recover with same-cycle retire
        do_reset();
        drive(2'd2, 2'd0, 7'd0, 7'd0, 1'b0);
        for (int k = 0; k < 5; k++) cyc();
        drive(2'd2, 2'd2, 7'd3, 7'd4, 1'b1);
        cyc();
        idle();
        chk("rec_head", dut.head_q, 2);
        chk("rec_rhead", dut.rhead_q, 2);
        chk("rec_free", fl_free_cnt, 32);
        chk("rec_pr0", fl_pr0, 34);
        chk("rec_pr1", fl_pr1, 35);
        drive(2'd2, 2'd0, 7'd0, 7'd0, 1'b0);
        cyc();
        idle();
        chk("rec_next_pr0", fl_pr0, 36);
        chk("rec_next_free", fl_free_cnt, 30);

        // 6: reset in the middle of a burst
        do_reset();
        drive(2'd2, 2'd0, 7'd0, 7'd0, 1'b0);
        for (int k = 0; k < 10; k++) cyc();
        chk("burst_head", dut.head_q, 20);
        chk("burst_pr0", fl_pr0, 52);
        reset = 1'b1;
        cyc();
        reset = 1'b0;
        idle();
        chk("mrst_pr0", fl_pr0, 32);
        chk("mrst_pr1", fl_pr1, 33);
        chk("mrst_free", fl_free_cnt, 32);
        chk("mrst_avail", fl_avail, 2);
        chk("mrst_head", dut.head_q, 0);

        // Randomised run against a queue model of free / in-flight / committed tags
        do_reset();
        free_q.delete();
        infl_q.delete();
        comm_q.delete();
        for (int i = 0; i < 32; i++) begin
            free_q.push_back(7'(32 + i));
            comm_q.push_back(7'(i));
        end
        for (int n = 0; n < 400; n++) begin
            ea = (free_q.size() < 2) ? free_q.size() : 2;
            ring_diff = dut.tail_q - dut.rhead_q;
            chk("rnd_ring", ring_diff, 32);
            chk("rnd_free", fl_free_cnt, free_q.size());
            chk("rnd_avail", fl_avail, ea);
            if (ea >= 1) chk("rnd_pr0", fl_pr0, free_q[0]);
            if (ea >= 2) chk("rnd_pr1", fl_pr1, free_q[1]);

            d    = $urandom_range(0, 2);
            maxr = (infl_q.size() < 2) ? infl_q.size() : 2;
            r    = $urandom_range(0, maxr);
            rec  = ($urandom_range(0, 15) == 0);
            t0   = (r >= 1) ? comm_q[0] : 7'h7f;
            t1   = (r == 2) ? comm_q[1] : 7'h7f;
            drive(2'(d), 2'(r), t0, t1, rec);

            al = rec ? 0 : ((d < ea) ? d : ea);
            for (int k = 0; k < r; k++) begin
                tg = comm_q.pop_front();
                comm_q.push_back(infl_q.pop_front());
                free_q.push_back(tg);
            end
            for (int k = 0; k < al; k++) infl_q.push_back(free_q.pop_front());
            if (rec) begin
                while (infl_q.size() > 0) free_q.push_front(infl_q.pop_back());
            end
            cyc();
        end
        idle();

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
